// File: rtl/bcd_tick_counter.sv
// rtl/bcd_tick_counter.sv - prescaled two-digit BCD up/down counter (00-99) with clear and load.
// Optional SATURATE_EN: hold at 99/00 instead of wrapping; wrap output then stays 0.
module bcd_tick_counter #(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       rst_in,
  input  logic       en,
  input  logic       up_dn,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       tick,
  output logic       wrap
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);

  logic [3:0]    ones_q, ones_d;
  logic [3:0]    tens_q, tens_d;
  logic [PW-1:0] div_cnt_q, div_cnt_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;

  // Loaded nibbles above 9 are forced to 9 so the hex decoders never see 10-15.
  function automatic logic [3:0] clamp9(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  always_comb begin
    ones_d    = ones_q;
    tens_d    = tens_q;
    div_cnt_d = div_cnt_q;
    tick_d    = 1'b0;
    wrap_d    = 1'b0;
    if (clr) begin
      ones_d    = 4'd0;
      tens_d    = 4'd0;
      div_cnt_d = '0;
    end else if (load) begin
      ones_d    = clamp9(load_val[3:0]);
      tens_d    = clamp9(load_val[7:4]);
      div_cnt_d = '0;
    end else if (en) begin
      if (div_cnt_q == DIV_LAST) begin
        div_cnt_d = '0;
        tick_d    = 1'b1;
        if (up_dn) begin
          if (ones_q == 4'd9 && tens_q == 4'd9) begin
`ifdef SATURATE_EN
            ones_d = 4'd9;
            tens_d = 4'd9;
`else
            ones_d = 4'd0;
            tens_d = 4'd0;
            wrap_d = 1'b1;
`endif
          end else if (ones_q == 4'd9) begin
            ones_d = 4'd0;
            tens_d = tens_q + 4'd1;
          end else begin
            ones_d = ones_q + 4'd1;
          end
        end else begin
          if (ones_q == 4'd0 && tens_q == 4'd0) begin
`ifdef SATURATE_EN
            ones_d = 4'd0;
            tens_d = 4'd0;
`else
            ones_d = 4'd9;
            tens_d = 4'd9;
            wrap_d = 1'b1;
`endif
          end else if (ones_q == 4'd0) begin
            ones_d = 4'd9;
            tens_d = tens_q - 4'd1;
          end else begin
            ones_d = ones_q - 4'd1;
          end
        end
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_in) begin
      ones_q    <= 4'd0;
      tens_q    <= 4'd0;
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      ones_q    <= ones_d;
      tens_q    <= tens_d;
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
    end
  end

  assign ones = ones_q;
  assign tens = tens_q;
  assign tick = tick_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// tb/tb_bcd_tick_counter.sv - self-checking bench for bcd_tick_counter with a decimal reference model.
module tb_bcd_tick_counter;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_in = 1'b0;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [3:0] ones, tens;
  logic       tick, wrap;

  int total = 0;
  int bad = 0;

  // Reference model: counter value as a plain integer 0..99 plus prescaler phase.
  int m_val = 0;
  int m_div = 0;
  bit m_tick = 1'b0;
  bit m_wrap = 1'b0;

  bcd_tick_counter #(.DIV(DIV)) dut (
    .clk(clk), .rst_in(rst_in), .en(en), .up_dn(up_dn), .clr(clr),
    .load(load), .load_val(load_val), .ones(ones), .tens(tens),
    .tick(tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    int t, o;
    m_tick = 1'b0;
    m_wrap = 1'b0;
    if (!rst_in) begin
      m_val = 0; m_div = 0;
    end else if (clr) begin
      m_val = 0; m_div = 0;
    end else if (load) begin
      t = (load_val[7:4] > 9) ? 9 : int'(load_val[7:4]);
      o = (load_val[3:0] > 9) ? 9 : int'(load_val[3:0]);
      m_val = t * 10 + o;
      m_div = 0;
    end else if (en) begin
      if (m_div == DIV - 1) begin
        m_div = 0;
        m_tick = 1'b1;
        if (up_dn) begin
`ifdef SATURATE_EN
          if (m_val < 99) m_val = m_val + 1;
`else
          if (m_val == 99) m_wrap = 1'b1;
          m_val = (m_val + 1) % 100;
`endif
        end else begin
`ifdef SATURATE_EN
          if (m_val > 0) m_val = m_val - 1;
`else
          if (m_val == 0) m_wrap = 1'b1;
          m_val = (m_val + 99) % 100;
`endif
        end
      end else begin
        m_div = m_div + 1;
      end
    end
  endtask

  function automatic logic [9:0] exp_vec();
    return {4'(m_val / 10), 4'(m_val % 10), m_tick, m_wrap};
  endfunction

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_in = 1'b0; en = 1'b0; up_dn = 1'b1;
    repeat (2) cyc();
    total++;
    if ({tens, ones, tick, wrap} !== 10'd0) begin
      bad++; $display("FAIL reset_state: got %h expected %h", {tens, ones, tick, wrap}, 10'd0);
    end
    rst_in = 1'b1; en = 1'b1; up_dn = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      cyc();
      total++;
      if ({tens, ones, tick, wrap} !== exp_vec()) begin
        bad++; $display("FAIL prescale_edge%0d: got %h expected %h", e, {tens, ones, tick, wrap}, exp_vec());
      end
      if (e == 4) begin
        total++;
        if (ones !== 4'd1 || tick !== 1'b1) begin
          bad++; $display("FAIL first_step_edge4: got ones=%0d tick=%0b expected ones=1 tick=1", ones, tick);
        end
      end
      if (e == 8) begin
        total++;
        if (ones !== 4'd2 || tick !== 1'b1) begin
          bad++; $display("FAIL second_step_edge8: got ones=%0d tick=%0b expected ones=2 tick=1", ones, tick);
        end
      end
    end
  endtask

  task automatic test_carry();
    en = 1'b1; up_dn = 1'b1;
    load_val = 8'h39; load = 1'b1; cyc(); load = 1'b0;
    repeat (DIV) cyc();
    total++;
    if ({tens, ones, tick, wrap} !== {4'd4, 4'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL decade_carry: got %h expected %h", {tens, ones, tick, wrap}, {4'd4, 4'd0, 1'b1, 1'b0});
    end
    load_val = 8'h99; load = 1'b1; cyc(); load = 1'b0;
    repeat (DIV) cyc();
    total++;
`ifdef SATURATE_EN
    if ({tens, ones, tick, wrap} !== {4'd9, 4'd9, 1'b1, 1'b0}) begin
      bad++; $display("FAIL up_limit: got %h expected %h", {tens, ones, tick, wrap}, {4'd9, 4'd9, 1'b1, 1'b0});
    end
`else
    if ({tens, ones, tick, wrap} !== {4'd0, 4'd0, 1'b1, 1'b1}) begin
      bad++; $display("FAIL up_limit: got %h expected %h", {tens, ones, tick, wrap}, {4'd0, 4'd0, 1'b1, 1'b1});
    end
`endif
    cyc();
    total++;
    if (tick !== 1'b0 || wrap !== 1'b0) begin
      bad++; $display("FAIL wrap_one_cycle: got tick=%0b wrap=%0b expected 0 0", tick, wrap);
    end
  endtask

  task automatic test_borrow();
    en = 1'b1; up_dn = 1'b0;
    load_val = 8'h10; load = 1'b1; cyc(); load = 1'b0;
    repeat (DIV) cyc();
    total++;
    if ({tens, ones, tick, wrap} !== {4'd0, 4'd9, 1'b1, 1'b0}) begin
      bad++; $display("FAIL down_borrow: got %h expected %h", {tens, ones, tick, wrap}, {4'd0, 4'd9, 1'b1, 1'b0});
    end
    load_val = 8'h00; load = 1'b1; cyc(); load = 1'b0;
    repeat (DIV) cyc();
    total++;
`ifdef SATURATE_EN
    if ({tens, ones, tick, wrap} !== {4'd0, 4'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL down_limit: got %h expected %h", {tens, ones, tick, wrap}, {4'd0, 4'd0, 1'b1, 1'b0});
    end
`else
    if ({tens, ones, tick, wrap} !== {4'd9, 4'd9, 1'b1, 1'b1}) begin
      bad++; $display("FAIL down_limit: got %h expected %h", {tens, ones, tick, wrap}, {4'd9, 4'd9, 1'b1, 1'b1});
    end
`endif
  endtask

  task automatic test_load_clamp();
    en = 1'b0;
    load_val = 8'hAF; load = 1'b1; cyc(); load = 1'b0;
    total++;
    if ({tens, ones, tick, wrap} !== {4'd9, 4'd9, 1'b0, 1'b0}) begin
      bad++; $display("FAIL load_clamp: got %h expected %h", {tens, ones, tick, wrap}, {4'd9, 4'd9, 1'b0, 1'b0});
    end
    load_val = 8'h55; load = 1'b1; cyc(); load = 1'b0;
    en = 1'b1; up_dn = 1'b1;
    repeat (DIV - 1) cyc();
    clr = 1'b1; load = 1'b1; load_val = 8'h77;
    cyc();
    clr = 1'b0; load = 1'b0;
    total++;
    if ({tens, ones, tick, wrap} !== 10'd0) begin
      bad++; $display("FAIL clr_load_on_step: got %h expected %h", {tens, ones, tick, wrap}, 10'd0);
    end
  endtask

  task automatic test_pause();
    clr = 1'b1; cyc(); clr = 1'b0;
    en = 1'b1; up_dn = 1'b1;
    repeat (2) cyc();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      total++;
      if (tick !== 1'b0 || ones !== 4'd0) begin
        bad++; $display("FAIL paused_%0d: got tick=%0b ones=%0d expected tick=0 ones=0", i, tick, ones);
      end
    end
    en = 1'b1;
    cyc();
    total++;
    if (tick !== 1'b0) begin
      bad++; $display("FAIL resume_first: got tick=%0b expected 0", tick);
    end
    cyc();
    total++;
    if (tick !== 1'b1 || ones !== 4'd1) begin
      bad++; $display("FAIL resume_step: got tick=%0b ones=%0d expected tick=1 ones=1", tick, ones);
    end
  endtask

  task automatic test_reset_mid();
    load_val = 8'h42; load = 1'b1; cyc(); load = 1'b0;
    en = 1'b1; up_dn = 1'b1;
    repeat (DIV - 1) cyc();
    rst_in = 1'b0; cyc(); rst_in = 1'b1;
    total++;
    if ({tens, ones, tick, wrap} !== 10'd0) begin
      bad++; $display("FAIL reset_mid: got %h expected %h", {tens, ones, tick, wrap}, 10'd0);
    end
    repeat (DIV - 1) cyc();
    total++;
    if (tick !== 1'b0 || ones !== 4'd0) begin
      bad++; $display("FAIL reset_restart: got tick=%0b ones=%0d expected 0 0", tick, ones);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst_in   = ($urandom_range(0, 79) != 0);
      clr      = ($urandom_range(0, 39) == 0);
      load     = ($urandom_range(0, 24) == 0);
      en       = ($urandom_range(0, 3) != 0);
      up_dn    = ($urandom_range(0, 2) != 0);
      load_val = 8'($urandom);
      cyc();
      total++;
      if ({tens, ones, tick, wrap} !== exp_vec()) begin
        bad++; $display("FAIL random_%0d: got %h expected %h", i, {tens, ones, tick, wrap}, exp_vec());
      end
      total++;
      if (ones > 4'd9 || tens > 4'd9 || (wrap && !tick)) begin
        bad++; $display("FAIL invariant_%0d: got tens=%0d ones=%0d tick=%0b wrap=%0b expected BCD digits", i, tens, ones, tick, wrap);
      end
    end
    rst_in = 1'b1; clr = 1'b0; load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_carry();
    test_borrow();
    test_load_clamp();
    test_pause();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
